// File: rtl/mem_access_unit.sv
// Data-memory access stage between EX/MEM and the D-cache port: owns the cache handshake,
// splits word-crossing accesses into two aligned beats (or faults them) and extends load data.
module mem_access_unit #(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic            busy,
    output logic            data_read,
    output logic            data_write,
    output logic [XLEN/8-1:0] data_mbe,
    output logic [XLEN-1:0] data_addr,
    output logic [XLEN-1:0] data_wdata,
    input  logic            data_resp,
    input  logic [XLEN-1:0] data_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int NBW  = OFFW + 2;
    localparam int LW   = 2 * NB;

    // state | meaning
    // IDLE  | ready to accept a request
    // BEAT0 | first (or only) aligned beat; faulted requests idle here one cycle without a cache access
    // BEAT1 | second beat of a word-crossing access
    // RESP  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              split_q, split_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;
    logic [XLEN-1:0]   beat1_q, beat1_d;

    logic [OFFW-1:0]   req_off;
    logic [NBW-1:0]    req_nbytes;
    logic              req_cross;
    logic              req_unal;
    logic              req_illegal;
    logic              req_fault;

    assign req_off     = req_addr[OFFW-1:0];
    assign req_nbytes  = NBW'(1) << req_size;
    assign req_cross   = (NBW'(req_off) + req_nbytes) > NBW'(NB);
    assign req_unal    = (NBW'(req_off) & (req_nbytes - NBW'(1))) != '0;
    assign req_illegal = (XLEN == 32) && (req_size == 2'd3);
    assign req_fault   = req_illegal || (!ALLOW_MISALIGNED && req_unal);

    logic [OFFW-1:0]   off_q;
    logic [NBW-1:0]    nbytes_q;
    logic [LW-1:0]     lane_win;
    logic [2*XLEN-1:0] wdata_win;
    logic [XLEN-1:0]   addr_base;
    logic [XLEN-1:0]   rd_raw;
    logic [XLEN-1:0]   ext_mask;
    logic              ext_sign;
    logic [XLEN-1:0]   ld_result;

    assign off_q     = addr_q[OFFW-1:0];
    assign nbytes_q  = NBW'(1) << size_q;
    // Two-line windows: low half feeds BEAT0, high half feeds BEAT1.
    assign lane_win  = ((LW'(1) << nbytes_q) - LW'(1)) << off_q;
    assign wdata_win = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
    assign addr_base = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign rd_raw    = XLEN'({beat1_q, beat0_q} >> {off_q, 3'b000});

    always_comb begin
        ext_mask = '1;
        ext_sign = 1'b0;
        case (size_q)
            2'd0: begin
                ext_mask = XLEN'(8'hFF);
                ext_sign = rd_raw[7];
            end
            2'd1: begin
                ext_mask = XLEN'(16'hFFFF);
                ext_sign = rd_raw[15];
            end
            2'd2: begin
                ext_mask = XLEN'(32'hFFFF_FFFF);
                ext_sign = rd_raw[31];
            end
            default: begin
                ext_mask = '1;
                ext_sign = rd_raw[XLEN-1];
            end
        endcase
        ld_result = (rd_raw & ext_mask) | ((!uns_q && ext_sign) ? ~ext_mask : '0);
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        split_d = split_q;
        fault_d = fault_q;
        beat0_d = beat0_q;
        beat1_d = beat1_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    fault_d = req_fault;
                    split_d = req_cross && !req_fault;
                    state_d = BEAT0;
                end
            end
            BEAT0: begin
                if (fault_q) begin
                    state_d = RESP;
                end else if (data_resp) begin
                    if (!write_q) beat0_d = data_rdata;
                    state_d = split_q ? BEAT1 : RESP;
                end
            end
            BEAT1: begin
                if (data_resp) begin
                    if (!write_q) beat1_d = data_rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            split_q <= 1'b0;
            fault_q <= 1'b0;
            beat0_q <= '0;
            beat1_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            split_q <= split_d;
            fault_q <= fault_d;
            beat0_q <= beat0_d;
            beat1_q <= beat1_d;
        end
    end

    logic in_beat0;
    logic in_beat1;

    assign in_beat0   = (state_q == BEAT0) && !fault_q;
    assign in_beat1   = (state_q == BEAT1);

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_fault = (state_q == RESP) && fault_q;
    assign resp_rdata = ((state_q == RESP) && !write_q && !fault_q) ? ld_result : '0;

    assign data_read  = (in_beat0 || in_beat1) && !write_q;
    assign data_write = (in_beat0 || in_beat1) && write_q;
    assign data_mbe   = in_beat0 ? lane_win[NB-1:0] :
                        in_beat1 ? lane_win[LW-1:NB] : '0;
    assign data_addr  = in_beat0 ? addr_base :
                        in_beat1 ? addr_base + XLEN'(NB) : '0;
    assign data_wdata = in_beat0 ? wdata_win[XLEN-1:0] :
                        in_beat1 ? wdata_win[2*XLEN-1:XLEN] : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (32-bit split, 32-bit faulting, 64-bit split)
// driven through one selectable port set and checked against a byte-level reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, data_resp = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = '0, req_wdata = '0, data_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic        a_req_ready, a_resp_valid, a_resp_fault, a_busy, a_data_read, a_data_write;
    logic [31:0] a_resp_rdata, a_data_addr, a_data_wdata;
    logic [3:0]  a_data_mbe;
    logic        b_req_ready, b_resp_valid, b_resp_fault, b_busy, b_data_read, b_data_write;
    logic [31:0] b_resp_rdata, b_data_addr, b_data_wdata;
    logic [3:0]  b_data_mbe;
    logic        c_req_ready, c_resp_valid, c_resp_fault, c_busy, c_data_read, c_data_write;
    logic [63:0] c_resp_rdata, c_data_addr, c_data_wdata;
    logic [7:0]  c_data_mbe;

    logic rv_a, rv_b, rv_c;
    assign rv_a = req_valid && (sel == 2'd0);
    assign rv_b = req_valid && (sel == 2'd1);
    assign rv_c = req_valid && (sel == 2'd2);

    mem_access_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(a_req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr[31:0]),
        .req_wdata(req_wdata[31:0]), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
        .resp_fault(a_resp_fault), .busy(a_busy), .data_read(a_data_read), .data_write(a_data_write),
        .data_mbe(a_data_mbe), .data_addr(a_data_addr), .data_wdata(a_data_wdata),
        .data_resp(data_resp), .data_rdata(data_rdata[31:0]));

    mem_access_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(rv_b), .req_ready(b_req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr[31:0]),
        .req_wdata(req_wdata[31:0]), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .resp_fault(b_resp_fault), .busy(b_busy), .data_read(b_data_read), .data_write(b_data_write),
        .data_mbe(b_data_mbe), .data_addr(b_data_addr), .data_wdata(b_data_wdata),
        .data_resp(data_resp), .data_rdata(data_rdata[31:0]));

    mem_access_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) dut_c (
        .clk(clk), .rst(rst), .req_valid(rv_c), .req_ready(c_req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(c_resp_valid), .resp_rdata(c_resp_rdata),
        .resp_fault(c_resp_fault), .busy(c_busy), .data_read(c_data_read), .data_write(c_data_write),
        .data_mbe(c_data_mbe), .data_addr(c_data_addr), .data_wdata(c_data_wdata),
        .data_resp(data_resp), .data_rdata(data_rdata));

    logic        o_req_ready, o_resp_valid, o_resp_fault, o_busy, o_data_read, o_data_write;
    logic [63:0] o_resp_rdata, o_data_addr, o_data_wdata;
    logic [7:0]  o_data_mbe;

    always_comb begin
        o_req_ready = c_req_ready;   o_resp_valid = c_resp_valid; o_resp_fault = c_resp_fault;
        o_busy = c_busy;             o_data_read = c_data_read;   o_data_write = c_data_write;
        o_resp_rdata = c_resp_rdata; o_data_addr = c_data_addr;   o_data_wdata = c_data_wdata;
        o_data_mbe = c_data_mbe;
        if (sel == 2'd0) begin
            o_req_ready = a_req_ready;   o_resp_valid = a_resp_valid; o_resp_fault = a_resp_fault;
            o_busy = a_busy;             o_data_read = a_data_read;   o_data_write = a_data_write;
            o_resp_rdata = 64'(a_resp_rdata); o_data_addr = 64'(a_data_addr);
            o_data_wdata = 64'(a_data_wdata); o_data_mbe = 8'(a_data_mbe);
        end else if (sel == 2'd1) begin
            o_req_ready = b_req_ready;   o_resp_valid = b_resp_valid; o_resp_fault = b_resp_fault;
            o_busy = b_busy;             o_data_read = b_data_read;   o_data_write = b_data_write;
            o_resp_rdata = 64'(b_resp_rdata); o_data_addr = 64'(b_data_addr);
            o_data_wdata = 64'(b_data_wdata); o_data_mbe = 8'(b_data_mbe);
        end
    end

    logic [63:0] got_addr [2];
    logic [63:0] got_wd [2];
    logic [7:0]  got_mbe [2];
    logic [63:0] got_rdata;
    logic        got_fault;
    int          got_lat, got_nreq;

    // One complete access against the reference model; w0/w1 are cache wait cycles per beat.
    task automatic run_txn(input bit wr, input logic [1:0] sz, input bit uns, input logic [63:0] addr,
                           input logic [63:0] wd, input int w0, input int w1,
                           input logic [63:0] r0, input logic [63:0] r1);
        int xlen, nb, nby, off, exp_lat, nbeats, beat, wcnt, p;
        bit flt, split, done;
        logic [63:0] amask, exp_rd;
        logic [63:0] exp_addr [2];
        logic [63:0] exp_wd [2];
        logic [7:0]  exp_mbe [2];
        logic [7:0]  win [16];
        xlen  = (sel == 2'd2) ? 64 : 32;
        nb    = xlen / 8;
        amask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        addr &= amask; wd &= amask; r0 &= amask; r1 &= amask;
        nby   = 1 << int'(sz);
        off   = int'(addr[2:0]) % nb;
        flt   = (xlen == 32 && sz == 2'd3) || (sel == 2'd1 && (int'(addr[2:0]) % nby) != 0);
        split = !flt && (off + nby > nb);
        nbeats  = flt ? 0 : (split ? 2 : 1);
        exp_lat = flt ? 2 : nbeats + w0 + (split ? w1 : 0) + 1;
        exp_addr[0] = addr & ~(64'(nb - 1));
        exp_addr[1] = (exp_addr[0] + 64'(nb)) & amask;
        for (int b = 0; b < 2; b++) begin
            exp_wd[b] = '0; exp_mbe[b] = '0;
            for (int j = 0; j < nb; j++) begin
                p = b * nb + j - off;
                if (p >= 0 && p < nb)  exp_wd[b][8*j +: 8] = wd[8*p +: 8];
                if (p >= 0 && p < nby) exp_mbe[b][j] = 1'b1;
            end
        end
        for (int i = 0; i < 2 * nb; i++) win[i] = (i < nb) ? r0[8*i +: 8] : r1[8*(i-nb) +: 8];
        exp_rd = '0;
        if (!flt && !wr) begin
            for (int i = 0; i < nby; i++) exp_rd[8*i +: 8] = win[off + i];
            if (!uns && exp_rd[8*nby-1])
                for (int i = nby; i < nb; i++) exp_rd[8*i +: 8] = 8'hFF;
        end

        @(negedge clk);
        n_checks++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL accept_ready: got %b want 1", o_req_ready); end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        data_resp = 1'($urandom); data_rdata = {$urandom, $urandom};
        @(posedge clk);
        beat = 0; wcnt = 0; done = 1'b0; got_nreq = 0; got_lat = -1;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (o_resp_valid) begin
                done = 1'b1; got_lat = cyc; got_fault = o_resp_fault; got_rdata = o_resp_rdata;
                n_checks++; if (cyc != exp_lat) begin n_fail++; $display("FAIL latency: got %0d want %0d", cyc, exp_lat); end
                n_checks++; if (o_resp_fault !== flt) begin n_fail++; $display("FAIL resp_fault: got %b want %b", o_resp_fault, flt); end
                n_checks++; if (o_resp_rdata !== exp_rd) begin n_fail++; $display("FAIL resp_rdata: got %h want %h", o_resp_rdata, exp_rd); end
                n_checks++; if (beat != nbeats) begin n_fail++; $display("FAIL beat_count: got %0d want %0d", beat, nbeats); end
                data_resp = 1'($urandom);
            end else if (o_data_read || o_data_write) begin
                got_nreq++;
                n_checks++;
                if (beat >= nbeats) begin
                    n_fail++; $display("FAIL unexpected_req: beat %0d of %0d", beat, nbeats);
                    data_resp = 1'b1;
                end else begin
                    if (wcnt == 0) begin
                        got_addr[beat] = o_data_addr; got_mbe[beat] = o_data_mbe; got_wd[beat] = o_data_wdata;
                    end
                    if (o_data_write !== wr || o_data_read !== !wr) begin n_fail++; $display("FAIL beat_op: rd %b wr %b want write=%b", o_data_read, o_data_write, wr); end
                    n_checks++; if (o_data_addr !== exp_addr[beat]) begin n_fail++; $display("FAIL beat_addr%0d: got %h want %h", beat, o_data_addr, exp_addr[beat]); end
                    n_checks++; if (o_data_mbe !== exp_mbe[beat]) begin n_fail++; $display("FAIL beat_mbe%0d: got %b want %b", beat, o_data_mbe, exp_mbe[beat]); end
                    n_checks++; if (o_data_wdata !== exp_wd[beat]) begin n_fail++; $display("FAIL beat_wdata%0d: got %h want %h", beat, o_data_wdata, exp_wd[beat]); end
                    if (wcnt == ((beat == 0) ? w0 : w1)) begin
                        data_resp = 1'b1; data_rdata = (beat == 0) ? r0 : r1; beat++; wcnt = 0;
                    end else begin
                        data_resp = 1'b0; data_rdata = {$urandom, $urandom}; wcnt++;
                    end
                end
            end else begin
                data_resp = 1'($urandom); data_rdata = {$urandom, $urandom};
            end
        end
        if (!done) begin n_checks++; n_fail++; $display("FAIL timeout: no resp_valid within 40 cycles"); end
        @(negedge clk);
        data_resp = 1'b0;
        n_checks++; if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin n_fail++; $display("FAIL resp_pulse: valid %b ready %b want 0 1", o_resp_valid, o_req_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            n_checks++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready%0d: got %b want 1", s, o_req_ready); end
            n_checks++; if ({o_resp_valid, o_resp_fault, o_busy, o_data_read, o_data_write} !== 5'b0) begin n_fail++; $display("FAIL rst_flags%0d: got %b want 00000", s, {o_resp_valid, o_resp_fault, o_busy, o_data_read, o_data_write}); end
            n_checks++; if ({o_resp_rdata, o_data_addr, o_data_wdata, o_data_mbe} !== '0) begin n_fail++; $display("FAIL rst_buses%0d: rdata %h addr %h wdata %h mbe %b want 0", s, o_resp_rdata, o_data_addr, o_data_wdata, o_data_mbe); end
        end
        sel = 2'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed32();
        sel = 2'd0;
        run_txn(1'b0, 2'd2, 1'b0, 64'h100, 64'h0, 1, 0, 64'hDEADBEEF, 64'h0);
        n_checks++; if (got_addr[0] !== 64'h100 || got_mbe[0] !== 8'b1111) begin n_fail++; $display("FAIL lw_beat: addr %h mbe %b want 100 1111", got_addr[0], got_mbe[0]); end
        n_checks++; if (got_rdata !== 64'hDEADBEEF || got_lat != 3) begin n_fail++; $display("FAIL lw_result: rdata %h lat %0d want deadbeef 3", got_rdata, got_lat); end
        run_txn(1'b0, 2'd0, 1'b0, 64'h103, 64'h0, 0, 0, 64'h80112233, 64'h0);
        n_checks++; if (got_mbe[0] !== 8'b1000 || got_rdata !== 64'hFFFFFF80) begin n_fail++; $display("FAIL lb_signed: mbe %b rdata %h want 1000 ffffff80", got_mbe[0], got_rdata); end
        run_txn(1'b0, 2'd0, 1'b1, 64'h103, 64'h0, 0, 0, 64'h80112233, 64'h0);
        n_checks++; if (got_rdata !== 64'h80) begin n_fail++; $display("FAIL lbu: rdata %h want 80", got_rdata); end
        run_txn(1'b1, 2'd1, 1'b0, 64'h102, 64'h0000ABCD, 2, 0, 64'h0, 64'h0);
        n_checks++; if (got_wd[0] !== 64'hABCD0000 || got_mbe[0] !== 8'b1100 || got_nreq != 3) begin n_fail++; $display("FAIL sh: wdata %h mbe %b req_cycles %0d want abcd0000 1100 3", got_wd[0], got_mbe[0], got_nreq); end
    endtask

    task automatic test_misaligned();
        sel = 2'd0;
        run_txn(1'b0, 2'd2, 1'b0, 64'h102, 64'h0, 0, 0, 64'h44332211, 64'h88776655);
        n_checks++; if (got_addr[0] !== 64'h100 || got_addr[1] !== 64'h104) begin n_fail++; $display("FAIL split_addr: %h %h want 100 104", got_addr[0], got_addr[1]); end
        n_checks++; if (got_mbe[0] !== 8'b1100 || got_mbe[1] !== 8'b0011) begin n_fail++; $display("FAIL split_mbe: %b %b want 1100 0011", got_mbe[0], got_mbe[1]); end
        n_checks++; if (got_rdata !== 64'h66554433 || got_lat != 3) begin n_fail++; $display("FAIL split_load: rdata %h lat %0d want 66554433 3", got_rdata, got_lat); end
        run_txn(1'b1, 2'd2, 1'b0, 64'h103, 64'hA1B2C3D4, 1, 1, 64'h0, 64'h0);
        n_checks++; if (got_wd[0] !== 64'hD4000000 || got_mbe[0] !== 8'b1000) begin n_fail++; $display("FAIL split_st0: wdata %h mbe %b want d4000000 1000", got_wd[0], got_mbe[0]); end
        n_checks++; if (got_wd[1] !== 64'h00A1B2C3 || got_mbe[1] !== 8'b0111) begin n_fail++; $display("FAIL split_st1: wdata %h mbe %b want 00a1b2c3 0111", got_wd[1], got_mbe[1]); end
    endtask

    task automatic test_fault();
        sel = 2'd1;
        run_txn(1'b0, 2'd1, 1'b0, 64'h101, 64'h0, 0, 0, 64'h12345678, 64'h0);
        n_checks++; if (got_fault !== 1'b1 || got_lat != 2 || got_nreq != 0) begin n_fail++; $display("FAIL unal_fault: fault %b lat %0d req_cycles %0d want 1 2 0", got_fault, got_lat, got_nreq); end
        sel = 2'd0;
        run_txn(1'b0, 2'd3, 1'b0, 64'h100, 64'h0, 0, 0, 64'h0, 64'h0);
        n_checks++; if (got_fault !== 1'b1 || got_nreq != 0) begin n_fail++; $display("FAIL size3_fault: fault %b req_cycles %0d want 1 0", got_fault, got_nreq); end
    endtask

    task automatic test_dword64();
        sel = 2'd2;
        run_txn(1'b0, 2'd3, 1'b0, 64'h0C, 64'h0, 0, 1, 64'h8877665544332211, 64'h00FFEEDDCCBBAA99);
        n_checks++; if (got_addr[0] !== 64'h08 || got_addr[1] !== 64'h10) begin n_fail++; $display("FAIL ld_addr: %h %h want 8 10", got_addr[0], got_addr[1]); end
        n_checks++; if (got_rdata !== 64'hCCBBAA9988776655) begin n_fail++; $display("FAIL ld_data: %h want ccbbaa9988776655", got_rdata); end
    endtask

    task automatic test_spurious();
        sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_resp = 1'b1; data_rdata = {$urandom, $urandom};
            @(negedge clk);
            n_checks++; if (o_resp_valid !== 1'b0 || o_busy !== 1'b0 || o_data_read !== 1'b0) begin n_fail++; $display("FAIL spurious: valid %b busy %b read %b want 0 0 0", o_resp_valid, o_busy, o_data_read); end
        end
        data_resp = 1'b0;
    endtask

    task automatic test_back_to_back();
        sel = 2'd0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 64'h200;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (o_data_read !== 1'b1 || o_data_addr !== 64'h200) begin n_fail++; $display("FAIL b2b_beat: read %b addr %h want 1 200", o_data_read, o_data_addr); end
        data_resp = 1'b1; data_rdata = 64'h12345678;
        @(negedge clk);
        data_resp = 1'b0;
        n_checks++; if (o_resp_valid !== 1'b1 || o_resp_rdata !== 64'h12345678 || o_req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_resp: valid %b rdata %h ready %b want 1 12345678 0", o_resp_valid, o_resp_rdata, o_req_ready); end
        req_valid = 1'b1; req_size = 2'd0; req_addr = 64'h201;
        @(negedge clk);
        n_checks++; if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: valid %b ready %b busy %b want 0 1 0", o_resp_valid, o_req_ready, o_busy); end
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (o_data_read !== 1'b1 || o_data_mbe !== 8'b0010 || o_data_addr !== 64'h200) begin n_fail++; $display("FAIL b2b_second: read %b mbe %b addr %h want 1 0010 200", o_data_read, o_data_mbe, o_data_addr); end
        data_resp = 1'b1; data_rdata = 64'h00009A00;
        @(negedge clk);
        data_resp = 1'b0;
        n_checks++; if (o_resp_valid !== 1'b1 || o_resp_rdata !== 64'hFFFFFF9A) begin n_fail++; $display("FAIL b2b_result: valid %b rdata %h want 1 ffffff9a", o_resp_valid, o_resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            for (int n = 0; n < 30; n++)
                run_txn(1'($urandom), 2'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                        int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                        {$urandom, $urandom}, {$urandom, $urandom});
        end
    endtask

    task automatic test_reset_mid();
        sel = 2'd2;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'h0C;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (o_data_read !== 1'b1 || o_data_addr !== 64'h08 || o_data_mbe !== 8'hF0) begin n_fail++; $display("FAIL rm_beat0: read %b addr %h mbe %h want 1 8 f0", o_data_read, o_data_addr, o_data_mbe); end
        data_resp = 1'b1; data_rdata = {$urandom, $urandom};
        @(negedge clk);
        data_resp = 1'b0;
        n_checks++; if (o_data_read !== 1'b1 || o_data_addr !== 64'h10 || o_data_mbe !== 8'h0F) begin n_fail++; $display("FAIL rm_beat1: read %b addr %h mbe %h want 1 10 0f", o_data_read, o_data_addr, o_data_mbe); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (o_data_read !== 1'b0 || o_req_ready !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL rm_abort: read %b ready %b busy %b want 0 1 0", o_data_read, o_req_ready, o_busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_resp: resp_valid %b want 0", o_resp_valid); end
        end
        run_txn(1'b0, 2'd2, 1'b1, 64'h24, 64'h0, 0, 0, 64'hFEDCBA9876543210, 64'h0);
    endtask

    initial begin
        test_reset();
        test_directed32();
        test_misaligned();
        test_fault();
        test_dword64();
        test_spurious();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
